// File: rtl/stage_defs.sv
// Stage and opcode encodings shared by the stage sequencer and the stage-enable decoder.
package stage_defs;

  localparam logic [2:0] STG_IDLE      = 3'd0;
  localparam logic [2:0] STG_FETCH     = 3'd1;
  localparam logic [2:0] STG_DECODE    = 3'd2;
  localparam logic [2:0] STG_EXECUTE   = 3'd3;
  localparam logic [2:0] STG_MEMORY    = 3'd4;
  localparam logic [2:0] STG_WRITEBACK = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sequencer states; the active stages reuse the stage number as their encoding.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalted    = 3'd7
  } seq_state_e;

  // HALT behaves as a NOP for datapath purposes.
  function automatic logic is_nop_op(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/stage_sequencer_mem_wait_timer.sv
// Memory-stage wait timer: loads on start, counts down while enabled, flags expiry at zero.
module mem_wait_timer #(
  parameter int unsigned MemTimeout = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic en_i,
  output logic expired_o
);

  // Loaded with MemTimeout-1 so expiry coincides with the MemTimeout-th wait cycle.
  localparam int unsigned CntW = (MemTimeout > 2) ? $clog2(MemTimeout) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: reload on start, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CntW'(MemTimeout - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Instruction stage sequencer: walks each instruction through fetch..write-back,
// with run/step/halt control, store stall on Mem_Ready and a retired counter.
module stage_sequencer
  import stage_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Step,
  input  logic               Halt_Req,
  input  logic               Mem_Ready,
  input  logic [3:0]         Opcode,
  input  logic               IsStore,
  output logic [2:0]         Stage,
  output logic               NOP_FLAG,
  output logic               WillWriteTo_Memory_H_RF_L,
  output logic               Busy,
  output logic               Instr_Done,
  output logic               Halted,
  output logic               Timeout_Err,
  output logic [COUNT_W-1:0] Retired
);

  seq_state_e         state_q, state_d;
  logic               nop_q, nop_d;
  logic               store_q, store_d;
  logic               halt_q, halt_d;
  logic               halt_pend_q, halt_pend_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] retired_q, retired_d;

  logic dec_nop;
  logic dec_store;
  logic mem_expired;

  assign dec_nop   = is_nop_op(Opcode);
  assign dec_store = IsStore & ~dec_nop;

  // Wait counter restarts on every S4 entry (S3 always leads to S4).
  mem_wait_timer #(
    .MemTimeout(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .start_i  (state_q == StExecute),
    .en_i     (state_q == StMemory),
    .expired_o(mem_expired)
  );

  // Next-state logic: stage progression, decode latches, halt pending, sticky error, counter.
  always_comb begin
    state_d     = state_q;
    nop_d       = nop_q;
    store_d     = store_q;
    halt_d      = halt_q;
    timeout_d   = timeout_q;
    retired_d   = retired_q;
    halt_pend_d = halt_pend_q;

    unique case (state_q)
      StIdle: begin
        if (Run || Step) state_d = StFetch;
      end
      StFetch:   state_d = StDecode;
      StDecode: begin
        state_d = StExecute;
        nop_d   = dec_nop;
        store_d = dec_store;
        halt_d  = (Opcode == OP_HALT);
      end
      StExecute: state_d = StMemory;
      StMemory: begin
        if (!store_q || Mem_Ready) begin
          state_d = StWriteback;
        end else if (mem_expired) begin
          timeout_d = 1'b1;
          state_d   = StWriteback;
        end
      end
      StWriteback: begin
        retired_d = retired_q + COUNT_W'(1);
        if (halt_q) begin
          state_d = StHalted;
        end else if (halt_pend_q || Halt_Req || !Run) begin
          state_d = StIdle;
        end else begin
          state_d = StFetch;
        end
      end
      StHalted:  state_d = StHalted;
      default:   state_d = StIdle;
    endcase

    // Halt requests only register while an instruction is in flight.
    if (state_d == StIdle) begin
      halt_pend_d = 1'b0;
    end else if (Busy && Halt_Req) begin
      halt_pend_d = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      nop_q       <= 1'b0;
      store_q     <= 1'b0;
      halt_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      timeout_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      nop_q       <= nop_d;
      store_q     <= store_d;
      halt_q      <= halt_d;
      halt_pend_q <= halt_pend_d;
      timeout_q   <= timeout_d;
      retired_q   <= retired_d;
    end
  end

  // Output decode: decode-stage flags come straight from the IR, later stages use latches.
  always_comb begin
    Stage                     = STG_IDLE;
    NOP_FLAG                  = 1'b0;
    WillWriteTo_Memory_H_RF_L = 1'b0;
    unique case (state_q)
      StFetch:     Stage = STG_FETCH;
      StDecode: begin
        Stage                     = STG_DECODE;
        NOP_FLAG                  = dec_nop;
        WillWriteTo_Memory_H_RF_L = dec_store;
      end
      StExecute: begin
        Stage                     = STG_EXECUTE;
        NOP_FLAG                  = nop_q;
        WillWriteTo_Memory_H_RF_L = store_q;
      end
      StMemory: begin
        Stage                     = STG_MEMORY;
        NOP_FLAG                  = nop_q;
        WillWriteTo_Memory_H_RF_L = store_q;
      end
      StWriteback: begin
        Stage                     = STG_WRITEBACK;
        NOP_FLAG                  = nop_q;
        WillWriteTo_Memory_H_RF_L = store_q;
      end
      default:     Stage = STG_IDLE;
    endcase
  end

  assign Busy        = (Stage != STG_IDLE);
  assign Instr_Done  = (state_q == StWriteback);
  assign Halted      = (state_q == StHalted);
  assign Timeout_Err = timeout_q;
  assign Retired     = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed cases plus randomized instruction streams
// checked cycle by cycle against an instruction-level expected stage trace.
module tb_stage_sequencer;
  import stage_defs::*;

  localparam int unsigned MT = 15;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          halt_req = 1'b0;
  logic          mem_ready = 1'b0;
  logic [3:0]    opcode = 4'h0;
  logic          is_store = 1'b0;
  logic [2:0]    stage;
  logic          nop_flag;
  logic          will_write;
  logic          busy;
  logic          instr_done;
  logic          halted;
  logic          timeout_err;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;

  // Reference model state, tracked per instruction.
  int exp_retired = 0;
  bit exp_timeout = 0;
  bit exp_halted  = 0;
  int cur_stage   = 0;  // 0: sequencer idle before next instruction, 1: already in fetch

  stage_sequencer #(
    .MEM_TIMEOUT(MT),
    .COUNT_W    (CW)
  ) dut (
    .Clock                    (clk),
    .Reset                    (reset),
    .Run                      (run),
    .Step                     (step),
    .Halt_Req                 (halt_req),
    .Mem_Ready                (mem_ready),
    .Opcode                   (opcode),
    .IsStore                  (is_store),
    .Stage                    (stage),
    .NOP_FLAG                 (nop_flag),
    .WillWriteTo_Memory_H_RF_L(will_write),
    .Busy                     (busy),
    .Instr_Done               (instr_done),
    .Halted                   (halted),
    .Timeout_Err              (timeout_err),
    .Retired                  (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input int stg, input bit nop, input bit ww);
    check_eq("stage", 32'(stage), 32'(stg));
    check_eq("nop_flag", 32'(nop_flag), 32'(nop));
    check_eq("will_write", 32'(will_write), 32'(ww));
    check_eq("busy", 32'(busy), 32'(stg != 0));
    check_eq("instr_done", 32'(instr_done), 32'(stg == 5));
    check_eq("halted", 32'(halted), 32'(exp_halted));
    check_eq("timeout_err", 32'(timeout_err), 32'(exp_timeout));
    check_eq("retired", 32'(retired), 32'(exp_retired % (1 << CW)));
  endtask

  // Runs one instruction. rdy_at: S4 cycle in which Mem_Ready rises (beyond MT = never).
  // hreq_stage: stage during which Halt_Req pulses (0 = none). cont: keep Run high at S5.
  task automatic run_one(input logic [3:0] op, input bit st, input int rdy_at,
                         input int hreq_stage, input bit use_step, input bit cont);
    bit nop;
    bit real_store;
    int n4;
    int stg;
    int s4cnt;
    nop        = (op == OP_NOP) || (op == OP_HALT);
    real_store = st && !nop;
    n4         = real_store ? ((rdy_at <= int'(MT)) ? rdy_at : int'(MT)) : 1;
    opcode     = op;
    is_store   = st;
    if (cur_stage == 0) begin
      check_outputs(0, 0, 0);
      run  = !use_step;
      step = use_step;
      tick();
      step = 1'b0;
    end
    s4cnt = 0;
    for (int c = 0; c < 4 + n4; c++) begin
      stg = (c < 3) ? c + 1 : ((c < 3 + n4) ? 4 : 5);
      if (stg == 4) s4cnt++;
      if (stg == 5 && real_store && rdy_at > int'(MT)) exp_timeout = 1;
      check_outputs(stg, (stg >= 2) ? nop : 1'b0, (stg >= 2) ? real_store : 1'b0);
      if (real_store) mem_ready = (stg == 4) && (s4cnt == rdy_at);
      else            mem_ready = 1'($urandom_range(0, 1));
      halt_req = (stg == hreq_stage);
      step     = use_step && (stg == 3);
      if (stg == 5) run = use_step ? 1'b0 : cont;
      tick();
    end
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    step      = 1'b0;
    exp_retired++;
    if (op == OP_HALT) begin
      exp_halted = 1;
      cur_stage  = 0;
    end else if (hreq_stage != 0 || use_step || !cont) begin
      cur_stage = 0;
    end else begin
      cur_stage = 1;
    end
  endtask

  initial begin
    logic [3:0] op;
    bit         st;
    int         rdy;
    int         hreq;
    bit         use_step;
    bit         cont;

    // Reset state.
    tick();
    check_outputs(0, 0, 0);
    tick();
    reset = 1'b0;
    check_outputs(0, 0, 0);
    tick();
    check_outputs(0, 0, 0);

    // Directed: three back-to-back ALU instructions.
    run_one(4'h3, 0, 1, 0, 0, 1);
    run_one(4'h3, 0, 1, 0, 0, 1);
    run_one(4'h3, 0, 1, 0, 0, 0);
    // Store with Mem_Ready in the third S4 cycle.
    run_one(4'h5, 1, 3, 0, 0, 0);
    // Store with Mem_Ready in the first S4 cycle.
    run_one(4'h6, 1, 1, 0, 0, 0);
    // NOP flagged as store: no stall, no memory write.
    run_one(OP_NOP, 1, 5, 0, 0, 0);
    // Single step with Run low.
    run_one(4'h2, 0, 1, 0, 1, 0);
    // Halt request during S3 with Run high, and one during S5.
    run_one(4'h4, 0, 1, 3, 0, 1);
    run_one(4'h4, 0, 1, 5, 0, 1);
    // Store whose memory never answers.
    run_one(4'h7, 1, 100, 0, 0, 1);

    // Randomized instruction stream with idle gaps that pulse Halt_Req (must be ignored).
    for (int i = 0; i < 40; i++) begin
      if (cur_stage == 0) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          check_outputs(0, 0, 0);
          run      = 1'b0;
          halt_req = 1'($urandom_range(0, 1));
          tick();
        end
        halt_req = 1'b0;
      end
      op       = 4'($urandom_range(0, 14));
      st       = 1'($urandom_range(0, 1));
      rdy      = int'($urandom_range(1, 20));
      hreq     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 0;
      use_step = (cur_stage == 0) && ($urandom_range(0, 3) == 0);
      cont     = ($urandom_range(0, 4) != 0);
      run_one(op, st, rdy, hreq, use_step, cont);
    end

    // HALT opcode: stop, then Run and Step are ignored.
    run_one(OP_HALT, 1'($urandom_range(0, 1)), 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      check_outputs(0, 0, 0);
      run  = 1'b1;
      step = 1'(i % 2);
      tick();
    end
    step = 1'b0;
    run  = 1'b0;

    // Reset leaves HALTED and clears all sticky state.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_retired = 0;
    exp_timeout = 0;
    exp_halted  = 0;
    cur_stage   = 0;
    check_outputs(0, 0, 0);

    // Reset during S4 of a stalled store aborts without retiring.
    opcode   = 4'h8;
    is_store = 1'b1;
    run      = 1'b1;
    tick();
    check_outputs(1, 0, 0);
    tick();
    check_outputs(2, 0, 1);
    tick();
    check_outputs(3, 0, 1);
    tick();
    check_outputs(4, 0, 1);
    tick();
    check_outputs(4, 0, 1);
    reset = 1'b1;
    run   = 1'b0;
    tick();
    check_outputs(0, 0, 0);
    reset = 1'b0;
    tick();
    check_outputs(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Drives the 3-bit `Stage` number (plus `NOP_FLAG` and `WillWriteTo_Memory_H_RF_L`) consumed by the stage-enable decoder. It is the producer side of the stage interface. It steps every instruction through Fetch(1), Decode(2), Execute(3), Memory(4) and Write Back(5). It supports free-run, single-step, halt request, HALT-opcode stop, memory-ready stall with timeout, and a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles stage 4 waits for `Mem_Ready` before forcing progress.
- `COUNT_W`, default 16: width of the retired-instruction counter.
- `Clock`  in  1  the single clock. All state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Run`  in  1  level. Keep issuing instructions back-to-back.
- `Step`  in  1  pulse. In IDLE, with `Run`=0, executes exactly one instruction.
- `Halt_Req`  in  1  pulse. Finish the current instruction, then go to IDLE.
- `Mem_Ready`  in  1  memory-stage completion handshake.
- `Opcode`  in  4  IR opcode field. Valid during stage 2.
- `IsStore`  in  1  decoded store indicator. Valid during stage 2.
- `Stage`  out  3  0 = idle/halted, 1..5 = current stage.
- `NOP_FLAG`  out  1  current instruction is a NOP or HALT.
- `WillWriteTo_Memory_H_RF_L`  out  1  1 = store to RAM, 0 = write to the register file.
- `Busy`  out  1  `Stage`≠0.
- `Instr_Done`  out  1  high during the stage 5 cycle.
- `Halted`  out  1  a HALT opcode has retired. Sticky.
- `Timeout_Err`  out  1  sticky. Set when a `Mem_Ready` wait expired.
- `Retired`  out  COUNT_W  count of instructions completed.

## Operation
- States: IDLE, S1..S5, HALTED. `Stage` equals the state index; IDLE and HALTED output 0.
- IDLE → S1 when `Run`|`Step`. If both are asserted, `Run` wins; the effect is identical.
- S1 → S2 and S2 → S3 unconditionally. S3 → S4 unconditionally.
- At the S2 → S3 edge, three values are latched:
  - `nop_q` = (`Opcode`==OP_NOP)|(`Opcode`==OP_HALT)
  - `store_q` = `IsStore` & ~`nop_q`
  - `halt_q` = (`Opcode`==OP_HALT)
- `NOP_FLAG`:
  - S1 and IDLE: 0.
  - S2: combinational from `Opcode`.
  - S3..S5: `nop_q`.
- `WillWriteTo_Memory_H_RF_L` follows the same pattern using `IsStore`/`store_q`.
- S4 wait:
  - If `store_q`=1, stay in S4 until `Mem_Ready`=1, then go to S5.
  - Otherwise, one cycle in S4; `Mem_Ready` is ignored.
- S4 timeout:
  - The wait counter resets on S4 entry.
  - If it reaches MEM_TIMEOUT with no `Mem_Ready`, set `Timeout_Err` and go to S5.
- S5 exit, in priority order:
  1. `halt_q` → HALTED, `Halted`=1.
  2. Pending halt request or `Run`=0 → IDLE.
  3. Otherwise → S1.
- `Retired` increments at every S5 exit. It wraps modulo 2^COUNT_W.
- `Halt_Req` sets a pending flag while `Busy`. The flag clears on IDLE entry. `Halt_Req` is ignored in IDLE and HALTED.
- HALTED is left only by `Reset`. `Run` and `Step` are ignored there.
- `Step` pulses while `Busy` are ignored. `Step` is not queued.

## Timing
- Reset: state IDLE. `Stage`, `NOP_FLAG`, `WillWriteTo_Memory_H_RF_L`, `Busy`, `Instr_Done`, `Halted`, `Timeout_Err` = 0. `Retired` = 0. Internal latches, pending flag and wait counter = 0.
- Reset mid-instruction aborts to IDLE on the next edge. No S5 or `Retired` increment occurs.
- Latency: `Run` high at edge k puts `Stage`=1 in cycle k+1.
- A non-stalled instruction takes exactly 5 cycles. Back-to-back issue has no idle gap (S5 → S1).
- Store stall: `Mem_Ready` high in the n-th S4 cycle gives S5 on the next cycle.
  - `Mem_Ready` already high in the first S4 cycle gives 1 cycle of S4.
  - With no `Mem_Ready`, S4 lasts MEM_TIMEOUT cycles.
- `Halt_Req` in the same cycle as S5 counts: the next state is IDLE.
- `Reset` has priority over every other input.

## Structure
- Shared include/package `stage_defs`:
  - Stage encodings STG_IDLE=0, STG_FETCH=1, STG_DECODE=2, STG_EXECUTE=3, STG_MEMORY=4, STG_WRITEBACK=5.
  - OP_NOP=4'h0, OP_HALT=4'hF.
  - This file is shared with the stage-enable decoder.
- One sub-module, `mem_wait_timer`:
  - Function: load-on-start down-counter with `expired` output, parameterised by MEM_TIMEOUT.
  - Everything else is in one FSM always-block plus output decode.

## Test plan
- Run=1, Opcode=4'h3, IsStore=0 for 3 instructions → `Stage` 1,2,3,4,5 repeating with no gaps. `Retired`=3. `WillWriteTo_Memory_H_RF_L`=0.
- Store (IsStore=1), `Mem_Ready` raised in the 3rd S4 cycle → S4 lasts 3 cycles, then S5. `WillWriteTo_Memory_H_RF_L`=1 in S2..S5.
- Store with `Mem_Ready`=0 forever, MEM_TIMEOUT=15 → S4 lasts 15 cycles. `Timeout_Err`=1, stays 1 afterwards.
- Opcode=4'h0 (NOP) with IsStore=1 → `NOP_FLAG`=1 in S2..S5. `WillWriteTo_Memory_H_RF_L`=0. S4 lasts 1 cycle.
- Run=0, single `Step` pulse → exactly one 5-stage pass, back to `Stage`=0, `Retired`=1.
- `Halt_Req` in S3 with Run=1 → IDLE after S5.
- Opcode=4'hF → HALTED after S5, `Halted`=1, and `Run` is ignored.
- `Reset` in S4 → `Stage`=0 next cycle and `Retired` unchanged at 0.
